// File: rtl/addsub_pipe_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addsub_pipe_top : three-operand add/sub datapath behind an elastic          |
// | valid/ready pipeline of STAGES registers. ADDSUB_PIPE_OVF_EN adds ovf.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module addsub_pipe_top #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] done_cnt
`ifdef ADDSUB_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [1:0] c_mode_sum  = 2'b00;
    localparam logic [1:0] c_mode_diff = 2'b01;
    localparam logic [1:0] c_mode_aadd = 2'b10;
    localparam logic [1:0] c_mode_asub = 2'b11;

`ifdef ADDSUB_PIPE_OVF_EN
    // Two guard bits: bit WIDTH flags >= 2^WIDTH, bit WIDTH+1 flags negative.
    localparam int CW = WIDTH + 2;
    localparam int DW = WIDTH + 1;
`else
    localparam int CW = WIDTH;
    localparam int DW = WIDTH;
`endif

    logic [CW-1:0]     add_w;
    logic [CW-1:0]     sub_w;
    logic [CW-1:0]     full_w;
    logic [DW-1:0]     calc_w;

    logic [STAGES:0]   stage_ready;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [DW-1:0]     data_q [STAGES];
    logic [DW-1:0]     data_d [STAGES];
    logic [CNT_W-1:0]  done_cnt_q;
    logic [CNT_W-1:0]  done_cnt_d;
    logic              drain_w;

    always_comb begin
        add_w  = CW'(b) + CW'(c);
        sub_w  = CW'(b) - CW'(c);
        full_w = '0;
        case (mode)
            c_mode_sum:  full_w = add_w + sub_w;
            c_mode_diff: full_w = add_w - sub_w;
            c_mode_aadd: full_w = CW'(a) + add_w;
            c_mode_asub: full_w = CW'(a) - sub_w;
            default:     full_w = '0;
        endcase
`ifdef ADDSUB_PIPE_OVF_EN
        calc_w = {(|full_w[CW-1:WIDTH]), full_w[WIDTH-1:0]};
`else
        calc_w = full_w;
`endif
    end

    // Ready ripples from the output back to the input in one cycle.
    always_comb begin
        stage_ready         = '0;
        stage_ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stage_ready[k] = !valid_q[k] || stage_ready[k+1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (stage_ready[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = calc_w;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (stage_ready[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    assign drain_w = valid_q[STAGES-1] && out_ready;

    always_comb begin
        done_cnt_d = done_cnt_q;
        if (drain_w) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            done_cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            done_cnt_q <= done_cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign result    = data_q[STAGES-1][WIDTH-1:0];
    assign done_cnt  = done_cnt_q;
`ifdef ADDSUB_PIPE_OVF_EN
    assign ovf       = data_q[STAGES-1][WIDTH];
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_addsub_pipe_top : directed vectors for addsub_pipe_top (WIDTH=8,         |
// | STAGES=2) plus a CNT_W=4 instance for counter wrap. Revision: 1.0           |
// +----------------------------------------------------------------------------+
module tb_addsub_pipe_top;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [7:0] c = '0;
    logic [1:0] mode = '0;

    logic        in_ready, out_valid;
    logic [7:0]  result;
    logic [15:0] done_cnt;
    logic        in_ready4, out_valid4;
    logic [7:0]  result4;
    logic [3:0]  done_cnt4;
`ifdef ADDSUB_PIPE_OVF_EN
    logic        ovf, ovf4;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] va [8];
    logic [7:0] vb [8];
    logic [7:0] vc [8];
    logic [1:0] vm [8];
    logic [7:0] vr [8];
    logic       vo [8];

    addsub_pipe_top #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .done_cnt(done_cnt)
`ifdef ADDSUB_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    addsub_pipe_top #(.WIDTH(8), .STAGES(2), .CNT_W(4)) u_dut_cnt4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .c(c), .mode(mode), .out_valid(out_valid4),
        .out_ready(out_ready), .result(result4), .done_cnt(done_cnt4)
`ifdef ADDSUB_PIPE_OVF_EN
        , .ovf(ovf4)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic, input logic [1:0] im);
        in_valid = v;
        a        = ia;
        b        = ib;
        c        = ic;
        mode     = im;
    endtask

    task automatic set_vec(input int i, input logic [7:0] ia, input logic [7:0] ib,
                           input logic [7:0] ic, input logic [1:0] im,
                           input logic [7:0] ir, input logic io);
        va[i] = ia; vb[i] = ib; vc[i] = ic; vm[i] = im; vr[i] = ir; vo[i] = io;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) tick();
        rst_n     = 1'b1;
    endtask

    // Back-to-back stream with out_ready high: each result one cycle after its accept edge.
    task automatic run_vectors(input int n, input string name, input bit chk_ovf);
        logic exp_v;
        for (int cyc = 0; cyc < n + 3; cyc++) begin
            if (cyc < n) begin
                drive(1'b1, va[cyc], vb[cyc], vc[cyc], vm[cyc]);
                check_eq({name, "_in_ready"}, 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            exp_v = (cyc >= 1) && (cyc <= n);
            check_eq({name, "_out_valid"}, 32'(out_valid), 32'(exp_v));
            if (exp_v) begin
                check_eq({name, "_result"}, 32'(result), 32'(vr[cyc-1]));
`ifdef ADDSUB_PIPE_OVF_EN
                if (chk_ovf) check_eq({name, "_ovf"}, 32'(ovf), 32'(vo[cyc-1]));
`else
                if (chk_ovf) n_vec += 0;
`endif
            end
        end
        check_eq({name, "_done_cnt"}, 32'(done_cnt), 32'(n));
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result",    32'(result),    32'd0);
        check_eq("rst_done_cnt",  32'(done_cnt),  32'd0);
        check_eq("rst_done_cnt4", 32'(done_cnt4), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;

        // Basic modes 00 / 01
        set_vec(0, 8'd0, 8'd5, 8'd3, 2'b00, 8'd10, 1'b0);
        set_vec(1, 8'd0, 8'd5, 8'd3, 2'b01, 8'd6,  1'b0);
        run_vectors(2, "basic", 1'b0);

        // Wrap and ovf cases
        do_reset();
        set_vec(0, 8'd0,  8'd200, 8'd100, 2'b00, 8'd144, 1'b1);
        set_vec(1, 8'd10, 8'd3,   8'd1,   2'b11, 8'd8,   1'b0);
        set_vec(2, 8'd1,  8'd5,   8'd1,   2'b11, 8'd253, 1'b1);
        run_vectors(3, "ovf", 1'b1);

        // Eight back-to-back items across all modes
        do_reset();
        set_vec(0, 8'd0,   8'd1,   8'd1,   2'b00, 8'd2,   1'b0);
        set_vec(1, 8'd0,   8'd10,  8'd4,   2'b01, 8'd8,   1'b0);
        set_vec(2, 8'd7,   8'd2,   8'd3,   2'b10, 8'd12,  1'b0);
        set_vec(3, 8'd100, 8'd9,   8'd2,   2'b11, 8'd93,  1'b0);
        set_vec(4, 8'd0,   8'd128, 8'd0,   2'b00, 8'd0,   1'b0);
        set_vec(5, 8'd0,   8'd0,   8'd200, 2'b01, 8'd144, 1'b0);
        set_vec(6, 8'd255, 8'd1,   8'd0,   2'b10, 8'd0,   1'b0);
        set_vec(7, 8'd0,   8'd0,   8'd1,   2'b11, 8'd1,   1'b0);
        run_vectors(8, "stream", 1'b0);

        // Stall: two stages fill, third waits, then drains without a bubble
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 8'd0, 8'd3, 8'd0, 2'b00);
        tick();
        drive(1'b1, 8'd0, 8'd4, 8'd0, 2'b00);
        tick();
        check_eq("stall_out_valid", 32'(out_valid), 32'd1);
        check_eq("stall_result",    32'(result),    32'd6);
        drive(1'b1, 8'd0, 8'd5, 8'd0, 2'b00);
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_hold_in_ready",  32'(in_ready),  32'd0);
            check_eq("stall_hold_out_valid", 32'(out_valid), 32'd1);
            check_eq("stall_hold_result",    32'(result),    32'd6);
        end
        out_ready = 1'b1;
        #1;
        check_eq("drain_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("drain1_out_valid", 32'(out_valid), 32'd1);
        check_eq("drain1_result",    32'(result),    32'd8);
        tick();
        check_eq("drain2_out_valid", 32'(out_valid), 32'd1);
        check_eq("drain2_result",    32'(result),    32'd10);
        tick();
        check_eq("drain3_out_valid", 32'(out_valid), 32'd0);
        check_eq("drain_done_cnt",   32'(done_cnt),  32'd3);

        // Asynchronous reset with two items in flight
        do_reset();
        drive(1'b1, 8'd0, 8'd1, 8'd0, 2'b00);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check_eq("pre_arst_done_cnt", 32'(done_cnt), 32'd1);
        out_ready = 1'b0;
        drive(1'b1, 8'd0, 8'd3, 8'd0, 2'b00);
        tick();
        drive(1'b1, 8'd0, 8'd4, 8'd0, 2'b00);
        tick();
        in_valid = 1'b0;
        check_eq("pre_arst_out_valid", 32'(out_valid), 32'd1);
        check_eq("pre_arst_result",    32'(result),    32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_result",    32'(result),    32'd0);
        check_eq("arst_done_cnt",  32'(done_cnt),  32'd0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_arst_out_valid", 32'(out_valid), 32'd0);
        end
        check_eq("post_arst_done_cnt", 32'(done_cnt), 32'd0);

        // Counter wrap on the CNT_W=4 instance
        do_reset();
        drive(1'b1, 8'd0, 8'd1, 8'd1, 2'b00);
        repeat (17) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check_eq("wrap_done_cnt4", 32'(done_cnt4), 32'd1);
        check_eq("wrap_done_cnt",  32'(done_cnt),  32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
